// File: rtl/ones_run_generator_if.sv
// Request/stream bundle between a burst requester and the ones-run generator.
interface ones_run_generator_if #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic             abort;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             expect_y;
  logic             done;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output start, run_len, abort,
    input  ready, x, x_valid, expect_y, done, burst_cnt
  );

  modport slave (
    input  start, run_len, abort,
    output ready, x, x_valid, expect_y, done, burst_cnt
  );
endinterface

// File: rtl/ones_run_generator.sv
// Emits a run of N ones followed by one terminating zero per accepted request,
// plus the reference flag a Mealy zero detector must match.
module ones_run_generator #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  ones_run_generator_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ONES = 2'd1;
  localparam logic [1:0] ZERO = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] emitted_q,   emitted_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             ready_q,     ready_d;
  logic             x_q,         x_d;
  logic             x_valid_q,   x_valid_d;
  logic             expect_y_q,  expect_y_d;
  logic             done_q,      done_d;

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    emitted_d   = emitted_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = bus.run_len;
          emitted_d   = '0;
          state_d     = (bus.run_len != '0) ? ONES : ZERO;
        end
      end
      ONES: begin
        remaining_d = remaining_q - LEN_W'(1);
        emitted_d   = emitted_q + LEN_W'(1);
        if (bus.abort || remaining_q == LEN_W'(1)) begin
          state_d = ZERO;
        end
      end
      ZERO: begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land registered with it
  always_comb begin
    ready_d    = (state_d == IDLE);
    x_d        = (state_d == ONES);
    x_valid_d  = (state_d == ONES) || (state_d == ZERO);
    done_d     = (state_d == ZERO);
    expect_y_d = (state_d == ZERO) && (emitted_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      emitted_q   <= '0;
      burst_cnt_q <= '0;
      ready_q     <= 1'b1;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      expect_y_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      emitted_q   <= emitted_d;
      burst_cnt_q <= burst_cnt_d;
      ready_q     <= ready_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      expect_y_q  <= expect_y_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.x         = x_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.expect_y  = expect_y_q;
  assign bus.done      = done_q;
  assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_ones_run_generator.sv
// Directed bench for ones_run_generator: burst shapes, abort, reset, back-pressure and counter wrap.
module tb_ones_run_generator;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic prev_one  = 1'b0;
  logic saw_wrap  = 1'b0;
  logic [7:0] last_cnt;

  ones_run_generator_if #(.LEN_W(4), .CNT_W(8)) bus ();

  ones_run_generator #(.LEN_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // exp = {ready, x, x_valid, expect_y, done}
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {3'b000, bus.ready, bus.x, bus.x_valid, bus.expect_y, bus.done}, {3'b000, exp});
  endtask

  // Reference Mealy detector: flags a valid zero that directly follows a valid one
  task automatic det_step(input string tag);
    logic y;
    y = bus.x_valid && !bus.x && prev_one;
    chk(tag, {7'd0, bus.expect_y}, {7'd0, y});
    if (bus.x_valid) prev_one = bus.x;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.run_len = '0;
    bus.abort   = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    chk_out("reset_out", 5'b10000);
    chk("reset_cnt", bus.burst_cnt, 8'd0);
    reset = 1'b0;
    tick();
    chk_out("idle_after_reset", 5'b10000);

    // run_len=3 burst
    bus.start = 1'b1; bus.run_len = 4'd3;
    tick();
    bus.start = 1'b0; bus.run_len = 4'd9;
    chk_out("len3_c1", 5'b01100);
    tick(); chk_out("len3_c2", 5'b01100);
    tick(); chk_out("len3_c3", 5'b01100);
    tick(); chk_out("len3_zero", 5'b00111);
    tick(); chk_out("len3_idle", 5'b10000);
    chk("len3_cnt", bus.burst_cnt, 8'd1);

    // zero-length burst
    bus.start = 1'b1; bus.run_len = 4'd0;
    tick();
    bus.start = 1'b0;
    chk_out("len0_zero", 5'b00101);
    tick(); chk_out("len0_idle", 5'b10000);
    chk("len0_cnt", bus.burst_cnt, 8'd2);

    // run_len=15 aborted at third ONES edge; run_len change mid-burst ignored
    bus.start = 1'b1; bus.run_len = 4'd15;
    tick();
    bus.start = 1'b0; bus.run_len = 4'd1;
    chk_out("abort_c1", 5'b01100);
    bus.abort = 1'b0;
    tick(); chk_out("abort_c2", 5'b01100);
    tick(); chk_out("abort_c3", 5'b01100);
    bus.abort = 1'b1;
    tick(); chk_out("abort_zero", 5'b00111);
    bus.abort = 1'b0;
    tick(); chk_out("abort_idle", 5'b10000);
    chk("abort_cnt", bus.burst_cnt, 8'd3);

    // start held high with run_len=2: 1,1,0,idle repeating
    bus.start = 1'b1; bus.run_len = 4'd2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      case ((i - 1) % 4)
        0, 1:    chk_out("rep_one", 5'b01100);
        2:       chk_out("rep_zero", 5'b00111);
        default: chk_out("rep_idle", 5'b10000);
      endcase
      chk("rep_cnt", bus.burst_cnt, 8'(3 + i / 4));
    end
    bus.start = 1'b0;
    tick();
    chk_out("rep_stop", 5'b10000);

    // reset in the second ONES cycle of a run_len=5 burst
    bus.start = 1'b1; bus.run_len = 4'd5;
    tick();
    bus.start = 1'b0;
    chk_out("rst_c1", 5'b01100);
    tick();
    chk_out("rst_c2", 5'b01100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("rst_mid_out", 5'b10000);
    chk("rst_mid_cnt", bus.burst_cnt, 8'd0);
    tick();
    chk_out("rst_no_done", 5'b10000);
    bus.start = 1'b1; bus.run_len = 4'd1;
    tick();
    bus.start = 1'b0;
    chk_out("post_rst_one", 5'b01100);
    tick(); chk_out("post_rst_zero", 5'b00111);
    tick(); chk_out("post_rst_idle", 5'b10000);
    chk("post_rst_cnt", bus.burst_cnt, 8'd1);

    // 256 back-to-back run_len=1 bursts: counter wraps, detector model tracks expect_y
    bus.start = 1'b1; bus.run_len = 4'd1;
    prev_one = 1'b0;
    last_cnt = bus.burst_cnt;
    for (int b = 0; b < 256; b++) begin
      tick(); chk_out("wrap_one", 5'b01100);  det_step("det_one");
      tick(); chk_out("wrap_zero", 5'b00111); det_step("det_zero");
      tick(); chk_out("wrap_idle", 5'b10000); det_step("det_idle");
      chk("wrap_cnt", bus.burst_cnt, 8'(2 + b));
      if (last_cnt == 8'd255 && bus.burst_cnt == 8'd0) saw_wrap = 1'b1;
      last_cnt = bus.burst_cnt;
    end
    bus.start = 1'b0;
    chk("wrap_seen", {7'd0, saw_wrap}, 8'd1);
    tick();
    chk_out("final_idle", 5'b10000);
    chk("final_cnt", bus.burst_cnt, 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
